// File: rtl/mem_port_arbiter.sv
// Purpose : arbitrates a fetch port and a data port onto one single-outstanding memory port.
// Latency : request seen in IDLE -> gnt + o_m_req next cycle; port rvalid one cycle after i_m_rvalid.
// Backpressure: o_m_req and its payload hold until i_m_ready; requests are only sampled in IDLE.
//
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_if_req/i_if_addr                 fetch read request (held until o_if_gnt)
//   o_if_gnt/o_if_rvalid               fetch accept pulse / fetch response pulse
//   i_d_req/i_d_we/i_d_addr/
//   i_d_wdata/i_d_be                   data request and payload (held until o_d_gnt)
//   o_d_gnt/o_d_rvalid                 data accept pulse / data completion pulse
//   o_rdata                            registered response data shared by both ports
//   o_m_req/o_m_we/o_m_addr/
//   o_m_wdata/o_m_be, i_m_ready        memory request channel
//   i_m_rvalid/i_m_rdata               memory completion
//
// Build option: define ARB_STARVE_GUARD_EN to let fetch win after STARVE_LIMIT
// consecutive lost arbitrations; otherwise data has strict priority.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned ADDR_W       = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic              o_if_gnt,
   output logic              o_if_rvalid,
   input  logic              i_d_req,
   input  logic              i_d_we,
   input  logic [ADDR_W-1:0] i_d_addr,
   input  logic [31:0]       i_d_wdata,
   input  logic [3:0]        i_d_be,
   output logic              o_d_gnt,
   output logic              o_d_rvalid,
   output logic [31:0]       o_rdata,
   output logic              o_m_req,
   output logic              o_m_we,
   output logic [ADDR_W-1:0] o_m_addr,
   output logic [31:0]       o_m_wdata,
   output logic [3:0]        o_m_be,
   input  logic              i_m_ready,
   input  logic              i_m_rvalid,
   input  logic [31:0]       i_m_rdata
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
      $error("mem_port_arbiter: STARVE_LIMIT must be within 1..15");
   end

   logic [1:0] state;
   logic       owner_if;   // 1: outstanding transaction belongs to the fetch port
   logic       grant_if;   // fetch wins the arbitration taking place this cycle

`ifdef ARB_STARVE_GUARD_EN
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt;

   // Once fetch has lost LIMIT times in a row it takes the next arbitration.
   assign grant_if = i_if_req & (~i_d_req | (starve_cnt == LIMIT));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         starve_cnt <= '0;
      end else if (state == ST_IDLE) begin
         if (grant_if) begin
            starve_cnt <= '0;
         end else if (i_if_req && i_d_req && (starve_cnt < LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
         end
      end
   end
`else
   assign grant_if = i_if_req & ~i_d_req;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         owner_if    <= 1'b0;
         o_if_gnt    <= 1'b0;
         o_d_gnt     <= 1'b0;
         o_if_rvalid <= 1'b0;
         o_d_rvalid  <= 1'b0;
         o_rdata     <= '0;
         o_m_we      <= 1'b0;
         o_m_addr    <= '0;
         o_m_wdata   <= '0;
         o_m_be      <= '0;
      end else begin
         // Grant and response strobes are single-cycle pulses by default.
         o_if_gnt    <= 1'b0;
         o_d_gnt     <= 1'b0;
         o_if_rvalid <= 1'b0;
         o_d_rvalid  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_if_req || i_d_req) begin
                  state    <= ST_ISSUE;
                  owner_if <= grant_if;
                  if (grant_if) begin
                     o_if_gnt  <= 1'b1;
                     o_m_we    <= 1'b0;
                     o_m_addr  <= i_if_addr;
                     o_m_wdata <= '0;
                     o_m_be    <= 4'hF;
                  end else begin
                     o_d_gnt   <= 1'b1;
                     o_m_we    <= i_d_we;
                     o_m_addr  <= i_d_addr;
                     o_m_wdata <= i_d_wdata;
                     o_m_be    <= i_d_be;
                  end
               end
            end
            ST_ISSUE: begin
               if (i_m_ready) begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (i_m_rvalid) begin
                  state   <= ST_IDLE;
                  o_rdata <= i_m_rdata;
                  if (owner_if) begin
                     o_if_rvalid <= 1'b1;
                  end else begin
                     o_d_rvalid <= 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_m_req = (state == ST_ISSUE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_if_req;
   logic [31:0] i_if_addr;
   logic        o_if_gnt;
   logic        o_if_rvalid;
   logic        i_d_req;
   logic        i_d_we;
   logic [31:0] i_d_addr;
   logic [31:0] i_d_wdata;
   logic [3:0]  i_d_be;
   logic        o_d_gnt;
   logic        o_d_rvalid;
   logic [31:0] o_rdata;
   logic        o_m_req;
   logic        o_m_we;
   logic [31:0] o_m_addr;
   logic [31:0] o_m_wdata;
   logic [3:0]  o_m_be;
   logic        i_m_ready;
   logic        i_m_rvalid;
   logic [31:0] i_m_rdata;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_if_req(i_if_req), .i_if_addr(i_if_addr),
      .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid),
      .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr),
      .i_d_wdata(i_d_wdata), .i_d_be(i_d_be),
      .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_rdata(o_rdata),
      .o_m_req(o_m_req), .o_m_we(o_m_we), .o_m_addr(o_m_addr),
      .o_m_wdata(o_m_wdata), .o_m_be(o_m_be), .i_m_ready(i_m_ready),
      .i_m_rvalid(i_m_rvalid), .i_m_rdata(i_m_rdata)
   );

   always #5 i_clk = ~i_clk;

   // Advance one cycle; outputs are observed 1 time unit after the rising edge.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Complete read with a zero-wait memory: request, grant, ready, rvalid, port rvalid.
   task automatic run_read(input bit is_f, input logic [31:0] addr, input logic [31:0] data);
      if (is_f) begin
         i_if_req = 1'b1; i_if_addr = addr;
      end else begin
         i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = addr; i_d_be = 4'hF; i_d_wdata = 32'h0;
      end
      step();
      chk("rr_gnt", is_f ? o_if_gnt : o_d_gnt, 1);
      chk("rr_addr", o_m_addr, addr);
      i_if_req = 1'b0; i_d_req = 1'b0; i_m_ready = 1'b1;
      step();
      i_m_ready = 1'b0; i_m_rvalid = 1'b1; i_m_rdata = data;
      step();
      i_m_rvalid = 1'b0;
      chk("rr_rvalid", is_f ? o_if_rvalid : o_d_rvalid, 1);
      chk("rr_rdata", o_rdata, data);
   endtask

   initial begin
      logic [31:0] saved_addr;
      byte         got[$];
      byte         exp_seq[$];
      int          cnt;
      bit          pend;
      bit          pend_n;

      i_rst = 1'b1; i_if_req = 1'b0; i_if_addr = '0; i_d_req = 1'b0; i_d_we = 1'b0;
      i_d_addr = '0; i_d_wdata = '0; i_d_be = '0; i_m_ready = 1'b0; i_m_rvalid = 1'b0;
      i_m_rdata = '0;
      step();
      step();

      // Reset state
      chk("rst_m_req", o_m_req, 0);
      chk("rst_gnts", {o_if_gnt, o_d_gnt}, 0);
      chk("rst_rvalids", {o_if_rvalid, o_d_rvalid}, 0);
      chk("rst_rdata", o_rdata, 0);
      chk("rst_payload", {o_m_we, o_m_addr, o_m_be}, 0);

      // Fetch-only read, memory completes in cycle 3
      i_rst = 1'b0; i_if_req = 1'b1; i_if_addr = 32'h1000_0000;        // cycle 0
      step();                                                          // cycle 1
      chk("f_gnt", o_if_gnt, 1);
      chk("f_d_gnt", o_d_gnt, 0);
      chk("f_m_req", o_m_req, 1);
      chk("f_m_addr", o_m_addr, 32'h1000_0000);
      chk("f_m_we_be", {o_m_we, o_m_be}, 5'h0F);
      chk("f_m_wdata", o_m_wdata, 0);
      i_if_req = 1'b0; i_m_ready = 1'b1;
      step();                                                          // cycle 2
      chk("f_m_req_drop", o_m_req, 0);
      chk("f_gnt_pulse", o_if_gnt, 0);
      i_m_ready = 1'b0;
      step();                                                          // cycle 3
      chk("f_no_early_rvalid", o_if_rvalid, 0);
      i_m_rvalid = 1'b1; i_m_rdata = 32'hDEAD_BEEF;
      step();                                                          // cycle 4
      i_m_rvalid = 1'b0;
      chk("f_rvalid", o_if_rvalid, 1);
      chk("f_d_rvalid", o_d_rvalid, 0);
      chk("f_rdata", o_rdata, 32'hDEAD_BEEF);
      step();                                                          // cycle 5
      chk("f_rvalid_pulse", o_if_rvalid, 0);
      chk("f_rdata_hold", o_rdata, 32'hDEAD_BEEF);

      // Simultaneous fetch and data read: data first, fetch after data completes
      i_if_req = 1'b1; i_if_addr = 32'h0000_0100;
      i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h0000_0200; i_d_be = 4'hF;
      step();
      chk("both_d_gnt", o_d_gnt, 1);
      chk("both_if_gnt", o_if_gnt, 0);
      chk("both_addr", o_m_addr, 32'h0000_0200);
      i_d_req = 1'b0; i_m_ready = 1'b1;
      step();
      chk("both_no_ifgnt_wait", {o_if_gnt, o_m_req}, 0);
      i_m_ready = 1'b0; i_m_rvalid = 1'b1; i_m_rdata = 32'hA5A5_A5A5;
      step();
      i_m_rvalid = 1'b0;
      chk("both_d_rvalid", o_d_rvalid, 1);
      chk("both_if_rvalid", o_if_rvalid, 0);
      chk("both_rdata", o_rdata, 32'hA5A5_A5A5);
      chk("both_idle_no_req", {o_if_gnt, o_m_req}, 0);
      step();
      chk("both_if_gnt_late", o_if_gnt, 1);
      chk("both_if_addr", o_m_addr, 32'h0000_0100);
      chk("both_if_m_req", o_m_req, 1);
      i_if_req = 1'b0; i_m_ready = 1'b1;
      step();
      i_m_ready = 1'b0; i_m_rvalid = 1'b1; i_m_rdata = 32'h1111_1111;
      step();
      i_m_rvalid = 1'b0;
      chk("both_if_rvalid2", o_if_rvalid, 1);
      chk("both_rdata2", o_rdata, 32'h1111_1111);

      // Data write
      i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 32'h2000_0004;
      i_d_wdata = 32'h1234_5678; i_d_be = 4'h3;
      step();
      chk("wr_gnt", o_d_gnt, 1);
      chk("wr_we", o_m_we, 1);
      chk("wr_addr", o_m_addr, 32'h2000_0004);
      chk("wr_wdata", o_m_wdata, 32'h1234_5678);
      chk("wr_be", o_m_be, 4'h3);
      i_d_req = 1'b0; i_m_ready = 1'b1;
      step();
      i_m_ready = 1'b0; i_m_rvalid = 1'b1; i_m_rdata = 32'h0;
      step();
      i_m_rvalid = 1'b0;
      chk("wr_rvalid", o_d_rvalid, 1);
      chk("wr_if_rvalid", o_if_rvalid, 0);

      // Memory stalls 10 cycles in ISSUE
      i_if_req = 1'b1; i_if_addr = 32'h3000_0000;
      step();
      chk("stall_gnt", o_if_gnt, 1);
      saved_addr = o_m_addr;
      chk("stall_addr0", saved_addr, 32'h3000_0000);
      i_if_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("stall_m_req", o_m_req, 1);
         chk("stall_payload", {o_m_we, o_m_addr, o_m_be}, {1'b0, 32'h3000_0000, 4'hF});
         chk("stall_no_regnt", {o_if_gnt, o_d_gnt}, 0);
      end
      i_m_ready = 1'b1;
      step();
      chk("stall_m_req_drop", o_m_req, 0);
      i_m_ready = 1'b0; i_m_rvalid = 1'b1; i_m_rdata = 32'h0BAD_F00D;
      step();
      i_m_rvalid = 1'b0;
      chk("stall_rvalid", o_if_rvalid, 1);
      chk("stall_rdata", o_rdata, 32'h0BAD_F00D);

      // Both ports request continuously; reactive zero-wait memory
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      i_if_req = 1'b1; i_if_addr = 32'h0000_0F00;
      i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h0000_0D00; i_d_be = 4'hF;
      pend = 1'b0;
      for (int c = 0; c < 60 && got.size() < 10; c++) begin
         pend_n = o_m_req;
         i_m_ready = o_m_req;
         i_m_rvalid = pend;
         i_m_rdata = c;
         step();
         pend = pend_n;
         if (o_if_gnt && o_d_gnt) begin
            chk("cont_double_gnt", {o_if_gnt, o_d_gnt}, 2'b01);
         end
         if (o_d_gnt) got.push_back("D");
         if (o_if_gnt) got.push_back("F");
      end
      chk("cont_grant_count", got.size(), 10);
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_GUARD_EN
         if (cnt == 4) begin
            exp_seq.push_back("F"); cnt = 0;
         end else begin
            exp_seq.push_back("D"); cnt++;
         end
`else
         exp_seq.push_back("D");
`endif
      end
      for (int k = 0; k < 10 && k < got.size(); k++) begin
         chk($sformatf("cont_grant_%0d", k), got[k], exp_seq[k]);
      end

      // Reset while in WAIT, memory completion arrives the cycle after
      i_if_req = 1'b0; i_d_req = 1'b0; i_m_ready = 1'b0; i_m_rvalid = 1'b0;
      i_rst = 1'b1;
      step();
      step();
      i_rst = 1'b0;
      run_read(1'b1, 32'h0000_0040, 32'h7777_7777);
      i_if_req = 1'b1; i_if_addr = 32'h0000_0044;
      step();
      chk("rw_gnt", o_if_gnt, 1);
      i_if_req = 1'b0; i_m_ready = 1'b1;
      step();
      i_m_ready = 1'b0; i_rst = 1'b1;
      step();
      i_rst = 1'b0; i_m_rvalid = 1'b1; i_m_rdata = 32'h9999_9999;
      chk("rw_m_req", o_m_req, 0);
      chk("rw_rdata_cleared", o_rdata, 0);
      chk("rw_payload_cleared", {o_m_addr, o_m_be}, 0);
      step();
      i_m_rvalid = 1'b0;
      chk("rw_no_rvalid", {o_if_rvalid, o_d_rvalid}, 0);
      chk("rw_rdata_still0", o_rdata, 0);
      chk("rw_m_req_idle", o_m_req, 0);
      run_read(1'b0, 32'h0000_0050, 32'h0000_1234);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
